// File: rtl/sram22_pmodel.sv
// sram22_pmodel: parametrised behavioural SRAM22 macro model.
// Single-port word memory with per-segment write mask, 1- or 2-cycle read
// latency with a valid strobe, a reset-triggered sequential clear engine
// (busy while clearing) and an out-of-range access flag.
// Optional macro SRAM22_WRITE_X_EN: accepted writes drive dout to all-X.
module sram22_pmodel #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int RAM_DEPTH    = 1024,
    parameter int WMASK_WIDTH  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   busy,
    output logic                   addr_err
);
    localparam int SEG = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    // Reject parameter sets the model cannot represent.
    generate
        if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
            $error("sram22_pmodel: DATA_WIDTH must be divisible by WMASK_WIDTH");
        end
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
            $error("sram22_pmodel: READ_LATENCY must be 1 or 2");
        end
        if (RAM_DEPTH < 1 || longint'(RAM_DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
            $error("sram22_pmodel: RAM_DEPTH must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic {S_CLEAR, S_READY} state_t;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_wx_q, s1_wx_d;

    logic                  in_range, acc, rd_fire, wr_fire, wr_x;
    logic [DATA_WIDTH-1:0] rd_word, wr_merged;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  fin_valid, fin_x;
    logic [DATA_WIDTH-1:0] fin_data;

`ifdef SRAM22_WRITE_X_EN
    assign wr_x = wr_fire;
`else
    assign wr_x = 1'b0;
`endif

    // Access decode, clear sequencing, write merge and read pipeline next-state.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        in_range  = ({1'b0, addr} < (ADDR_WIDTH + 1)'(RAM_DEPTH));
        acc       = en && (state_q == S_READY);
        rd_fire   = acc && in_range && !we;
        wr_fire   = acc && in_range && we;
        err_d     = acc && !in_range;
        rd_word   = in_range ? mem[addr] : '0;

        wr_merged = rd_word;
        for (int j = 0; j < WMASK_WIDTH; j++) begin
            if (wmask[j]) wr_merged[j*SEG +: SEG] = din[j*SEG +: SEG];
        end

        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = wr_merged;
        if (state_q == S_CLEAR) begin
            mem_we     = !rst;
            mem_waddr  = clr_addr_q;
            mem_wdata  = '0;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) state_d = S_READY;
        end else begin
            mem_we = wr_fire;
        end

        s1_valid_d = rd_fire;
        s1_wx_d    = wr_x;
        s1_data_d  = rd_fire ? rd_word : s1_data_q;

        if (READ_LATENCY == 1) begin
            fin_valid = rd_fire;
            fin_data  = rd_word;
            fin_x     = wr_x;
        end else begin
            fin_valid = s1_valid_q;
            fin_data  = s1_data_q;
            fin_x     = s1_wx_q;
        end

        valid_d = fin_valid;
        dout_d  = dout_q;
        if (fin_valid)  dout_d = fin_data;
        else if (fin_x) dout_d = 'x;
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_wx_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            s1_wx_q    <= s1_wx_d;
        end
    end

    // Memory array write port (clear engine or accepted write).
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the clear engine zeroes it after rst drops.
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q == S_CLEAR);
    assign addr_err   = err_q;

endmodule

// File: doc/sram22_pmodel.md
Name: sram22_pmodel

Overview:
- Parametrised, next-generation behavioural SRAM22 macro model used for simulation of generated SRAM instances.
- Generalises the fixed single-mask model in four ways:
  - arbitrary data width and depth, including non-power-of-two depth;
  - per-segment write mask;
  - selectable 1- or 2-cycle read latency with a valid strobe;
  - a reset-triggered sequential clear engine with a busy flag.
- Out-of-range accesses are detected and flagged.

Parameters:
- DATA_WIDTH, 32: bits per word.
- ADDR_WIDTH, 10: address bits.
- RAM_DEPTH, 1024: number of words. Must satisfy RAM_DEPTH <= 2**ADDR_WIDTH.
- WMASK_WIDTH, 4: mask segments. DATA_WIDTH must be divisible by WMASK_WIDTH; segment width SEG = DATA_WIDTH/WMASK_WIDTH.
- READ_LATENCY, 1: 1 or 2 cycles from read edge to dout_valid.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  chip enable; no access when low
- we  input  1  write enable (1 = write, 0 = read when en)
- wmask  input  WMASK_WIDTH  per-segment write mask
- addr  input  ADDR_WIDTH  word address
- din  input  DATA_WIDTH  write data
- dout  output  DATA_WIDTH  read data, registered
- dout_valid  output  1  one-cycle strobe; dout holds new read data
- busy  output  1  clear engine active; all accesses ignored
- addr_err  output  1  one-cycle pulse on out-of-range access

Behaviour:
- Async reset (rst=1):
  - dout=0, dout_valid=0, addr_err=0, busy=1.
  - Clear counter = 0; state = CLEAR.
  - Read pipeline valid bits cleared.
  - Memory array untouched while rst is held.
- State CLEAR:
  - Each clk edge after rst deasserts writes 0 to mem[clr_addr], then clr_addr increments.
  - On the edge that clears word RAM_DEPTH-1, state goes to READY and busy drops.
  - Clear therefore takes exactly RAM_DEPTH edges.
- State READY: busy=0; accesses accepted. No transitions other than rst.
- Reset during CLEAR restarts the clear from address 0.
- Accepted access condition: en=1, busy=0, addr<RAM_DEPTH.
- Out-of-range access (en=1, busy=0, addr>=RAM_DEPTH): no memory change, no read valid. addr_err=1 for the following cycle only.
- Write (accepted, we=1): for each j with wmask[j]=1, mem[addr][j*SEG +: SEG] <= din[j*SEG +: SEG]. Unmasked segments are preserved. wmask=0 is a legal no-op write.
- Read (accepted, we=0):
  - READ_LATENCY=1: mem[addr] is captured into dout at the access edge; dout_valid=1 during the next cycle.
  - READ_LATENCY=2: data passes through one extra register; dout and dout_valid are one cycle later.
  - Back-to-back reads are fully pipelined, one per cycle.
- Read of an address written on the previous edge returns the new data. There is no same-edge read and write (single port).
- dout holds its last value when no read completes.
- dout_valid is 0 in every cycle in which no read result emerges.
- Accesses while busy=1 are silently dropped: no write, no valid, no addr_err.
- Illegal parameters (non-divisible mask, READ_LATENCY not 1 or 2, RAM_DEPTH > 2**ADDR_WIDTH) stop elaboration with an error.

Optional Feature:
- Macro: SRAM22_WRITE_X_EN.
- Defined: every accepted write cycle drives dout to all-X at the write edge (READ_LATENCY=1) or one edge later (READ_LATENCY=2). This models undefined output during write. dout_valid stays 0 for these cycles.
- Undefined: dout holds its previous value across writes.

Test Plan:
- Reset then idle, defaults:
  - rst pulse -> busy=1 for exactly 1024 edges after deassert, then 0.
  - Read of addr 0x3FF -> dout=0x00000000, dout_valid one cycle later.
- Masked write:
  - Write 0xFFFFFFFF to addr 5 with wmask=4'hF, then write 0x12345678 with wmask=4'b0101.
  - Read addr 5 -> 0xFF34FF78.
- Latency:
  - READ_LATENCY=2; write 0xA5A5A5A5 to addr 9, then read addr 9 on the next cycle.
  - dout_valid asserts exactly 2 cycles after the read edge; no valid in between.
- Busy drop and mid-clear reset:
  - Assert rst at clear count 300; deassert.
  - busy stays high for a further 1024 edges.
  - Write attempted while busy leaves the word reading 0 afterwards.
- Out of range:
  - RAM_DEPTH=1000; read addr 1000 -> addr_err=1 for one cycle, dout_valid=0, dout unchanged.
  - Write to addr 1001, then read addr 1001 mod 1000 = 1 -> reads 0.
- SRAM22_WRITE_X_EN defined:
  - Read 0x1 from addr 2, then write addr 3 -> dout becomes all-X after the write edge.
  - Same sequence without the macro -> dout holds 0x00000001.
